// File: rtl/btb_lookup_pkg.sv
// ============================================================================
// Module : btb_lookup_pkg
// Brief  : Shared BTB types, way count and lookup FSM state encoding.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package btb_lookup_pkg;

  localparam int BTB_WAYS = 4;

  typedef logic [1:0] btb_way_t;
  typedef logic [1:0] btb_ctr_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } btb_state_t;

endpackage

`default_nettype wire

// File: rtl/btb_lookup_way_match.sv
// ============================================================================
// Module : btb_way_match
// Brief  : 4-way tag compare with lowest-way-wins priority encode.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module btb_way_match
  import btb_lookup_pkg::*;
#(
  parameter int TW = 12
) (
  input  logic [TW-1:0] tag,
  input  logic [TW-1:0] way_tag   [BTB_WAYS],
  input  logic          way_valid [BTB_WAYS],
  output logic          hit,
  output btb_way_t      way
);

  logic [BTB_WAYS-1:0] match;

  for (genvar w = 0; w < BTB_WAYS; w++) begin : g_cmp
    assign match[w] = way_valid[w] && (way_tag[w] == tag);
  end

  // Scan from the top so the lowest matching way is the last one written.
  always_comb begin
    hit = |match;
    way = '0;
    for (int w = BTB_WAYS - 1; w >= 0; w--) begin
      if (match[w]) way = btb_way_t'(w);
    end
  end

endmodule

`default_nettype wire

// File: rtl/btb_lookup.sv
// ============================================================================
// Module : btb_lookup
// Brief  : Fetch-side BTB read controller: registered prediction one cycle
//          after accept, plus an invalidate-all flush walk.
//          Optional macro BTB_LRU_TOUCH_EN drives lru_touch on predicted hits.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module btb_lookup
  import btb_lookup_pkg::*;
#(
  parameter  int SETS_LOG2 = 3,
  localparam int TW        = 15 - SETS_LOG2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic [15:0]          req_pc,
  output logic                 req_ready,
  input  logic                 stall,
  output logic [SETS_LOG2-1:0] rd_index,
  input  logic [TW-1:0]        way_tag    [BTB_WAYS],
  input  logic                 way_valid  [BTB_WAYS],
  input  logic [15:0]          way_target [BTB_WAYS],
  input  btb_ctr_t             way_ctr    [BTB_WAYS],
  output logic                 resp_valid,
  output logic                 resp_hit,
  output logic                 resp_taken,
  output logic [15:0]          resp_target,
  output btb_way_t             resp_way,
  input  logic                 flush_req,
  output logic                 flush_busy,
  output logic                 flush_done,
  output logic                 inval_en,
  output logic [SETS_LOG2-1:0] inval_index,
  output logic                 lru_touch,
  output btb_way_t             lru_touch_way
);

  btb_state_t  state;
  logic [15:0] pc_q;
  logic        pend;
  logic        hit;
  btb_way_t    way;
  logic        accept;
  logic        taken;
  logic        ctr_lsb_unused;

  assign req_ready = (state == ST_IDLE) && !flush_req && !stall;
  assign accept    = req_valid && req_ready;
  assign taken     = hit && way_ctr[way][1];
  assign ctr_lsb_unused = ^{way_ctr[0][0], way_ctr[1][0], way_ctr[2][0], way_ctr[3][0]};

  btb_way_match #(.TW(TW)) u_match (
    .tag       (pc_q[15:SETS_LOG2+1]),
    .way_tag   (way_tag),
    .way_valid (way_valid),
    .hit       (hit),
    .way       (way)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      pc_q        <= '0;
      pend        <= 1'b0;
      rd_index    <= '0;
      resp_valid  <= 1'b0;
      resp_hit    <= 1'b0;
      resp_taken  <= 1'b0;
      resp_target <= '0;
      resp_way    <= '0;
      flush_busy  <= 1'b0;
      flush_done  <= 1'b0;
      inval_en    <= 1'b0;
      inval_index <= '0;
    end else begin
      flush_done <= 1'b0;
      if (accept) begin
        rd_index <= req_pc[SETS_LOG2:1];
        pc_q     <= req_pc;
      end
      // The response stage and its pending flag freeze together under stall,
      // so the array data for the held rd_index stays consistent.
      if (!stall) begin
        pend        <= accept;
        resp_valid  <= pend;
        resp_hit    <= pend && hit;
        resp_taken  <= pend && taken;
        resp_target <= taken ? way_target[way] : pc_q + 16'd2;
        resp_way    <= (pend && hit) ? way : '0;
      end
      case (state)
        ST_IDLE: begin
          if (flush_req) begin
            state       <= ST_FLUSH;
            flush_busy  <= 1'b1;
            inval_en    <= 1'b1;
            inval_index <= '0;
          end
        end
        ST_FLUSH: begin
          if (inval_index == {SETS_LOG2{1'b1}}) begin
            state       <= ST_IDLE;
            flush_busy  <= 1'b0;
            inval_en    <= 1'b0;
            inval_index <= '0;
            flush_done  <= 1'b1;
          end else begin
            inval_index <= inval_index + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef BTB_LRU_TOUCH_EN
  assign lru_touch     = resp_valid && resp_hit && !stall;
  assign lru_touch_way = resp_way;
`else
  assign lru_touch     = 1'b0;
  assign lru_touch_way = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_btb_lookup.sv
// ============================================================================
// Module : tb_btb_lookup
// Brief  : Random and directed bench for btb_lookup against a cycle-level
//          reference model with its own tag arrays (BTB_LRU_TOUCH_EN aware).
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_btb_lookup;
  import btb_lookup_pkg::*;

  localparam int SL2   = 3;
  localparam int TW    = 15 - SL2;
  localparam int NSETS = 1 << SL2;

  logic clk = 1'b0;
  logic rst;
  logic req_valid, req_ready, stall, flush_req;
  logic [15:0] req_pc;
  logic [SL2-1:0] rd_index, inval_index;
  logic [TW-1:0] way_tag [BTB_WAYS];
  logic way_valid [BTB_WAYS];
  logic [15:0] way_target [BTB_WAYS];
  btb_ctr_t way_ctr [BTB_WAYS];
  logic resp_valid, resp_hit, resp_taken;
  logic [15:0] resp_target;
  btb_way_t resp_way, lru_touch_way;
  logic flush_busy, flush_done, inval_en, lru_touch;

  // Behavioural BTB arrays, read through the DUT's registered index.
  logic [TW-1:0] a_tag [NSETS][BTB_WAYS];
  logic          a_val [NSETS][BTB_WAYS];
  logic [15:0]   a_tgt [NSETS][BTB_WAYS];
  btb_ctr_t      a_ctr [NSETS][BTB_WAYS];

  // Reference model state
  bit m_flush, m_pend, e_valid, e_hit, e_taken, e_done;
  int m_fidx, m_rdidx, e_way;
  logic [15:0] m_pend_pc, e_target;

  int n_vec = 0;
  int n_err = 0;
  int n_seen;

  always #5 clk = ~clk;

  always_comb begin
    for (int w = 0; w < BTB_WAYS; w++) begin
      way_tag[w]    = a_tag[rd_index][w];
      way_valid[w]  = a_val[rd_index][w];
      way_target[w] = a_tgt[rd_index][w];
      way_ctr[w]    = a_ctr[rd_index][w];
    end
  end

  btb_lookup #(.SETS_LOG2(SL2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_pc(req_pc), .req_ready(req_ready),
    .stall(stall), .rd_index(rd_index), .way_tag(way_tag), .way_valid(way_valid),
    .way_target(way_target), .way_ctr(way_ctr), .resp_valid(resp_valid), .resp_hit(resp_hit),
    .resp_taken(resp_taken), .resp_target(resp_target), .resp_way(resp_way),
    .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done),
    .inval_en(inval_en), .inval_index(inval_index), .lru_touch(lru_touch),
    .lru_touch_way(lru_touch_way)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_way(input int s, input int w, input bit v, input logic [TW-1:0] t,
                         input logic [15:0] tgt, input btb_ctr_t c);
    a_val[s][w] = v; a_tag[s][w] = t; a_tgt[s][w] = tgt; a_ctr[s][w] = c;
  endtask

  task automatic predict(input logic [15:0] pc);
    int s;
    s = int'(pc[SL2:1]);
    e_hit = 1'b0;
    e_way = 0;
    for (int w = BTB_WAYS - 1; w >= 0; w--) begin
      if (a_val[s][w] && a_tag[s][w] == pc[15:SL2+1]) begin
        e_hit = 1'b1;
        e_way = w;
      end
    end
    e_taken  = e_hit && a_ctr[s][e_way][1];
    e_target = e_taken ? a_tgt[s][e_way] : pc + 16'd2;
  endtask

  task automatic model_reset();
    m_flush = 0; m_pend = 0; m_fidx = 0; m_rdidx = 0; m_pend_pc = '0;
    e_valid = 0; e_hit = 0; e_taken = 0; e_done = 0; e_way = 0; e_target = '0;
  endtask

  task automatic model_update();
    bit acc;
    acc = !m_flush && !flush_req && !stall && req_valid;
    if (!stall) begin
      e_valid = m_pend;
      if (m_pend) predict(m_pend_pc);
    end
    e_done = 0;
    if (m_flush) begin
      if (m_fidx == NSETS - 1) begin
        m_flush = 0; m_fidx = 0; e_done = 1;
      end else begin
        m_fidx++;
      end
    end else if (flush_req) begin
      m_flush = 1; m_fidx = 0;
    end
    if (acc) begin
      m_pend = 1; m_pend_pc = req_pc; m_rdidx = int'(req_pc[SL2:1]);
    end else if (!stall) begin
      m_pend = 0;
    end
  endtask

  task automatic compare_all();
    check("req_ready", req_ready, !m_flush && !flush_req && !stall);
    check("rd_index", rd_index, m_rdidx);
    check("resp_valid", resp_valid, e_valid);
    if (e_valid) begin
      check("resp_hit", resp_hit, e_hit);
      check("resp_taken", resp_taken, e_taken);
      check("resp_target", resp_target, e_target);
      check("resp_way", resp_way, e_hit ? e_way : 0);
    end
    check("flush_busy", flush_busy, m_flush);
    check("inval_en", inval_en, m_flush);
    check("inval_index", inval_index, m_flush ? m_fidx : 0);
    check("flush_done", flush_done, e_done);
`ifdef BTB_LRU_TOUCH_EN
    check("lru_touch", lru_touch, e_valid && e_hit && !stall);
    check("lru_touch_way", lru_touch_way, (e_valid && e_hit && !stall) ? e_way : 0);
`else
    check("lru_touch", lru_touch, 0);
    check("lru_touch_way", lru_touch_way, 0);
`endif
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input bit rv, input logic [15:0] pc, input bit st, input bit fl);
    req_valid = rv; req_pc = pc; stall = st; flush_req = fl;
    #1 compare_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic reset_check(input string tag);
    check({tag, "_resp_valid"}, resp_valid, 0);
    check({tag, "_resp_hit"}, resp_hit, 0);
    check({tag, "_resp_taken"}, resp_taken, 0);
    check({tag, "_resp_target"}, resp_target, 0);
    check({tag, "_resp_way"}, resp_way, 0);
    check({tag, "_flush_busy"}, flush_busy, 0);
    check({tag, "_flush_done"}, flush_done, 0);
    check({tag, "_inval_en"}, inval_en, 0);
    check({tag, "_inval_index"}, inval_index, 0);
    check({tag, "_lru_touch"}, lru_touch, 0);
    check({tag, "_rd_index"}, rd_index, 0);
  endtask

  initial begin
    for (int s = 0; s < NSETS; s++)
      for (int w = 0; w < BTB_WAYS; w++)
        set_way(s, w, 1'($urandom_range(0, 1)), TW'($urandom_range(0, 3)), 16'($urandom),
                btb_ctr_t'($urandom_range(0, 3)));
    rst = 1'b1; req_valid = 0; req_pc = '0; stall = 0; flush_req = 0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_check("reset");
    rst = 1'b0;

    // Single taken hit on way 2
    for (int w = 0; w < BTB_WAYS; w++) begin
      set_way(3, w, 0, '0, '0, '0);
      set_way(7, w, 0, '0, '0, '0);
    end
    set_way(3, 2, 1, 12'h0A3, 16'h1234, 2'b10);
    step(1, 16'h0A36, 0, 0);
    step(0, 16'h0000, 0, 0);
    check("t1_hit", resp_hit, 1);
    check("t1_taken", resp_taken, 1);
    check("t1_way", resp_way, 2);
    check("t1_target", resp_target, 16'h1234);

    // Weakly not-taken hit, then a miss at the top of the address space
    a_ctr[3][2] = 2'b01;
    step(1, 16'h0A36, 0, 0);
    step(0, 16'h0000, 0, 0);
    check("t2_hit", resp_hit, 1);
    check("t2_taken", resp_taken, 0);
    check("t2_target", resp_target, 16'h0A38);
    step(1, 16'hFFFE, 0, 0);
    step(0, 16'h0000, 0, 0);
    check("t2_wrap_hit", resp_hit, 0);
    check("t2_wrap_target", resp_target, 16'h0000);

    // Multi-hit priority
    set_way(3, 2, 0, 12'h0A3, 16'h1234, 2'b10);
    set_way(3, 1, 1, 12'h0A3, 16'h2222, 2'b11);
    set_way(3, 3, 1, 12'h0A3, 16'h3333, 2'b11);
    step(1, 16'h0A36, 0, 0);
    step(0, 16'h0000, 0, 0);
    check("t3_way", resp_way, 1);
    check("t3_target", resp_target, 16'h2222);
`ifdef BTB_LRU_TOUCH_EN
    check("t3_lru_touch", lru_touch, 1);
    check("t3_lru_way", lru_touch_way, 1);
`else
    check("t3_lru_touch", lru_touch, 0);
`endif

    // Stall after accept: exactly one response once released
    step(1, 16'h0A36, 0, 0);
    n_seen = 0;
    for (int i = 0; i < 3; i++) begin
      step(1, 16'h1000, 1, 0);
      n_seen += int'(resp_valid);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 16'h0000, 0, 0);
      n_seen += int'(resp_valid);
    end
    check("t4_resp_count", n_seen, 1);

    // Full flush walk; flush_req held early in the walk must not restart it
    step(0, 16'h0000, 0, 1);
    n_seen = int'(inval_en);
    for (int i = 0; i < 10; i++) begin
      step(1, 16'h0A36, 0, i < 3);
      n_seen += int'(inval_en);
      if (flush_done) n_seen += 100;
    end
    check("t5_inval_cycles_plus_done", n_seen, 108);

    // Reset in the middle of a flush walk
    step(0, 16'h0000, 0, 1);
    for (int i = 0; i < 20 && m_fidx != 4; i++) step(0, 16'h0000, 0, 0);
    check("t6_at_index4", inval_index, 4);
    rst = 1'b1;
    #1;
    model_reset();
    reset_check("t6_mid_reset");
    @(negedge clk);
    rst = 1'b0;
    step(1, 16'h0A36, 0, 0);
    step(0, 16'h0000, 0, 0);
    check("t6_resp_after_reset", resp_valid, 1);

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      set_way($urandom_range(0, NSETS - 1), $urandom_range(0, BTB_WAYS - 1),
              1'($urandom_range(0, 1)), TW'($urandom_range(0, 3)), 16'($urandom),
              btb_ctr_t'($urandom_range(0, 3)));
      step($urandom_range(0, 3) != 0, {12'($urandom_range(0, 3)), 4'($urandom)},
           $urandom_range(0, 4) == 0, $urandom_range(0, 39) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
